// File: rtl/ctrl_pkg.sv
// Shared types and constants for the control sequencer: FSM states,
// opcodes, decode classes, ALU operation codes and instruction fields.
package ctrl_pkg;

    localparam int INSTR_W = 16;
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_F_ADDR,
        ST_F_MEM,
        ST_F_MBR,
        ST_F_IR,
        ST_DECODE,
        ST_E_ADDR,
        ST_E_MEM,
        ST_E_MBR,
        ST_E_DO,
        ST_E_STORE,
        ST_HALT,
        ST_TRAP
    } state_e;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_LOAD  = 4'h1,
        OP_STORE = 4'h2,
        OP_ADD   = 4'h3,
        OP_SUB   = 4'h4,
        OP_AND   = 4'h5,
        OP_OR    = 4'h6,
        OP_XOR   = 4'h7,
        OP_JUMP  = 4'h8,
        OP_JZ    = 4'h9,
        OP_JNEG  = 4'hA,
        OP_HALT  = 4'hF
    } opcode_e;

    // What DECODE should do with the current instruction.
    typedef enum logic [2:0] {
        CLS_NEXT,   // nothing to execute, fetch the next instruction
        CLS_JUMP,   // load PC from the operand, then fetch
        CLS_EXEC,   // operand read followed by an accumulator update
        CLS_STORE,  // operand write of the accumulator
        CLS_HALT,
        CLS_TRAP
    } class_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: classifies the instruction for the FSM and
// selects the ALU operation and accumulator source.
// Build option: CTRL_COND_JUMP_EN enables JZ/JNEG; without it they trap.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [3:0] i_opcode,
    input  logic       i_acc_zero,
    input  logic       i_acc_neg,
    output class_e     o_class,
    output logic [2:0] o_alu_op,
    output logic       o_acc_sel
);

`ifndef CTRL_COND_JUMP_EN
    // Accumulator flags only matter for conditional jumps.
    logic w_unused_flags;
    assign w_unused_flags = i_acc_zero ^ i_acc_neg;
`endif

    // Opcode to class / ALU-op mapping; unlisted opcodes are illegal.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
        o_class   = CLS_TRAP;
        o_alu_op  = ALU_ADD;
        o_acc_sel = 1'b0;
        case (i_opcode)
            OP_NOP:   o_class = CLS_NEXT;
            OP_LOAD:  begin o_class = CLS_EXEC; o_acc_sel = 1'b1; end
            OP_STORE: o_class = CLS_STORE;
            OP_ADD:   begin o_class = CLS_EXEC; o_alu_op = ALU_ADD; end
            OP_SUB:   begin o_class = CLS_EXEC; o_alu_op = ALU_SUB; end
            OP_AND:   begin o_class = CLS_EXEC; o_alu_op = ALU_AND; end
            OP_OR:    begin o_class = CLS_EXEC; o_alu_op = ALU_OR;  end
            OP_XOR:   begin o_class = CLS_EXEC; o_alu_op = ALU_XOR; end
            OP_JUMP:  o_class = CLS_JUMP;
`ifdef CTRL_COND_JUMP_EN
            OP_JZ:    o_class = i_acc_zero ? CLS_JUMP : CLS_NEXT;
            OP_JNEG:  o_class = i_acc_neg  ? CLS_JUMP : CLS_NEXT;
`endif
            OP_HALT:  o_class = CLS_HALT;
            default:  o_class = CLS_TRAP;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute control FSM for a simple accumulator CPU.
// Build option: CTRL_COND_JUMP_EN (handled in ctrl_decode) enables JZ/JNEG.
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int          ADDR_W   = 12,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] ir,
    input  logic [15:0] acc,
    output logic        mar_load,
    output logic        mbr_load,
    output logic        ir_load,
    output logic        acc_load,
    output logic        pc_inc,
    output logic        pc_load,
    output logic        mem_we,
    output logic        mar_sel,
    output logic        acc_sel,
    output logic [2:0]  alu_op,
    output logic [15:0] pc_load_val,
    output logic        busy,
    output logic        halted,
    output logic        trap
);

    state_e      r_state;
    state_e      w_next;
    logic        r_live;       // low until the first edge after reset release
    class_e      w_class;
    logic [2:0]  w_alu_op;
    logic        w_acc_sel;
    logic [15:0] w_target;
    logic        w_unused_ir;

    assign w_target    = 16'(ir[ADDR_W-1:0]);
    assign w_unused_ir = ^ir;

    ctrl_decode u_decode (
        .i_opcode   (ir[OPC_MSB:OPC_LSB]),
        .i_acc_zero (acc == 16'h0000),
        .i_acc_neg  (acc[15]),
        .o_class    (w_class),
        .o_alu_op   (w_alu_op),
        .o_acc_sel  (w_acc_sel)
    );

    // State register; r_live keeps the release cycle strobe-free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            r_state <= ST_IDLE;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_live  <= 1'b1;
        end
    end

    // Next-state and strobe decode for the current state.
    always_comb begin
        w_next      = r_state;
        mar_load    = 1'b0;
        mbr_load    = 1'b0;
        ir_load     = 1'b0;
        acc_load    = 1'b0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        mem_we      = 1'b0;
        mar_sel     = 1'b0;
        acc_sel     = 1'b0;
        alu_op      = ALU_ADD;
        pc_load_val = 16'h0000;
        busy        = 1'b1;
        halted      = 1'b0;
        trap        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                // IDLE is only reachable through reset, so leaving it is always the first fetch.
                if (start && r_live) begin
                    pc_load     = 1'b1;
                    pc_load_val = RESET_PC;
                    w_next      = ST_F_ADDR;
                end
            end
            ST_F_ADDR: begin
                mar_load = 1'b1;
                w_next   = ST_F_MEM;
            end
            ST_F_MEM: w_next = ST_F_MBR;
            ST_F_MBR: begin
                mbr_load = 1'b1;
                w_next   = ST_F_IR;
            end
            ST_F_IR: begin
                ir_load = 1'b1;
                pc_inc  = 1'b1;
                w_next  = ST_DECODE;
            end
            ST_DECODE: begin
                pc_load_val = w_target;
                case (w_class)
                    CLS_NEXT:  w_next = ST_F_ADDR;
                    CLS_JUMP:  begin pc_load = 1'b1; w_next = ST_F_ADDR; end
                    CLS_EXEC:  w_next = ST_E_ADDR;
                    CLS_STORE: w_next = ST_E_ADDR;
                    CLS_HALT:  w_next = ST_HALT;
                    default:   w_next = ST_TRAP;
                endcase
            end
            ST_E_ADDR: begin
                mar_load = 1'b1;
                mar_sel  = 1'b1;
                w_next   = (w_class == CLS_STORE) ? ST_E_STORE : ST_E_MEM;
            end
            ST_E_MEM: w_next = ST_E_MBR;
            ST_E_MBR: begin
                mbr_load = 1'b1;
                w_next   = ST_E_DO;
            end
            ST_E_DO: begin
                acc_load = 1'b1;
                acc_sel  = w_acc_sel;
                alu_op   = w_alu_op;
                w_next   = ST_F_ADDR;
            end
            ST_E_STORE: begin
                mem_we = 1'b1;
                w_next = ST_F_ADDR;
            end
            ST_HALT: begin
                busy   = 1'b0;
                halted = 1'b1;
                if (start) w_next = ST_F_ADDR;
            end
            ST_TRAP: begin
                busy = 1'b0;
                trap = 1'b1;
            end
            default: begin
                busy   = 1'b0;
                w_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed testbench for control_sequencer: per-cycle strobe/status vectors
// for each instruction class, reset behaviour, HALT resume and TRAP lock.
module tb_control_sequencer;

    // Output vector bit positions: {busy,halted,trap,mar_load,mbr_load,ir_load,
    // acc_load,pc_inc,pc_load,mem_we,mar_sel,acc_sel}
    localparam logic [11:0] BUSY = 12'h800, HLT = 12'h400, TRP = 12'h200;
    localparam logic [11:0] MARL = 12'h100, MBRL = 12'h080, IRL = 12'h040;
    localparam logic [11:0] ACCL = 12'h020, PCI = 12'h010, PCL = 12'h008;
    localparam logic [11:0] WE = 12'h004, MSEL = 12'h002, ASEL = 12'h001;

    localparam logic [11:0] O_FADDR = BUSY | MARL;
    localparam logic [11:0] O_FMEM  = BUSY;
    localparam logic [11:0] O_FMBR  = BUSY | MBRL;
    localparam logic [11:0] O_FIR   = BUSY | IRL | PCI;
    localparam logic [11:0] O_DEC   = BUSY;
    localparam logic [11:0] O_DECJ  = BUSY | PCL;
    localparam logic [11:0] O_EADDR = BUSY | MARL | MSEL;
    localparam logic [11:0] O_EMEM  = BUSY;
    localparam logic [11:0] O_EMBR  = BUSY | MBRL;
    localparam logic [11:0] O_EALU  = BUSY | ACCL;
    localparam logic [11:0] O_ELD   = BUSY | ACCL | ASEL;
    localparam logic [11:0] O_EST   = BUSY | WE;

    localparam logic [15:0] TB_RESET_PC = 16'h0A50;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] ir = 16'h0000;
    logic [15:0] acc = 16'h0000;
    logic        mar_load, mbr_load, ir_load, acc_load, pc_inc, pc_load, mem_we;
    logic        mar_sel, acc_sel, busy, halted, trap;
    logic [2:0]  alu_op;
    logic [15:0] pc_load_val;

    int n_cmp = 0;
    int n_bad = 0;

    control_sequencer #(.ADDR_W(12), .RESET_PC(TB_RESET_PC)) dut (
        .clk(clk), .reset(reset), .start(start), .ir(ir), .acc(acc),
        .mar_load(mar_load), .mbr_load(mbr_load), .ir_load(ir_load),
        .acc_load(acc_load), .pc_inc(pc_inc), .pc_load(pc_load), .mem_we(mem_we),
        .mar_sel(mar_sel), .acc_sel(acc_sel), .alu_op(alu_op),
        .pc_load_val(pc_load_val), .busy(busy), .halted(halted), .trap(trap)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] outs();
        return {busy, halted, trap, mar_load, mbr_load, ir_load, acc_load,
                pc_inc, pc_load, mem_we, mar_sel, acc_sel};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Hold reset for a cycle, release mid-cycle, then wait one edge so IDLE accepts start.
    task automatic release_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    // From IDLE: pulse start so the next cycle is the first F_ADDR.
    task automatic begin_run(input logic [15:0] word);
        ir = word;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b1;
        ir = 16'h8FFF;
        tick();
        tick();
        #1;
        n_cmp++;
        if (outs() !== 12'h000) begin n_bad++; $display("FAIL reset_outs got %h expected %h", outs(), 12'h000); end
        n_cmp++;
        if (pc_load_val !== 16'h0000) begin n_bad++; $display("FAIL reset_pcval got %h expected %h", pc_load_val, 16'h0000); end
        n_cmp++;
        if (alu_op !== 3'b000) begin n_bad++; $display("FAIL reset_aluop got %b expected %b", alu_op, 3'b000); end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (outs() !== 12'h000) begin n_bad++; $display("FAIL release_cycle got %h expected %h", outs(), 12'h000); end
        tick();
        start = 1'b0;
        #1;
        n_cmp++;
        if (outs() !== 12'h000) begin n_bad++; $display("FAIL idle_outs got %h expected %h", outs(), 12'h000); end
    endtask

    task automatic test_first_fetch();
        logic [11:0] seq [6];
        seq = '{O_FADDR, O_FMEM, O_FMBR, O_FIR, O_DEC, O_FADDR};
        ir = 16'h0000;
        start = 1'b1;
        #1;
        n_cmp++;
        if (outs() !== PCL) begin n_bad++; $display("FAIL first_pcload got %h expected %h", outs(), PCL); end
        n_cmp++;
        if (pc_load_val !== TB_RESET_PC) begin n_bad++; $display("FAIL first_pcval got %h expected %h", pc_load_val, TB_RESET_PC); end
        tick();
        start = 1'b0;
        #1;
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (outs() !== seq[i]) begin n_bad++; $display("FAIL nop_c%0d got %h expected %h", i, outs(), seq[i]); end
            if (i < 5) tick();
        end
    endtask

    // ALU ops with start held high: start must be ignored while busy.
    task automatic test_alu();
        logic [15:0] words [5];
        logic [2:0]  ops [5];
        logic [11:0] seq [10];
        words = '{16'h3005, 16'h4010, 16'h5020, 16'h6030, 16'h7040};
        ops   = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};
        seq   = '{O_FADDR, O_FMEM, O_FMBR, O_FIR, O_DEC, O_EADDR, O_EMEM, O_EMBR, O_EALU, O_FADDR};
        start = 1'b1;
        for (int j = 0; j < 5; j++) begin
            ir = words[j];
            #1;
            for (int i = 0; i < 10; i++) begin
                n_cmp++;
                if (outs() !== seq[i]) begin n_bad++; $display("FAIL alu%0d_c%0d got %h expected %h", j, i, outs(), seq[i]); end
                if (i == 8) begin
                    n_cmp++;
                    if (alu_op !== ops[j]) begin n_bad++; $display("FAIL alu%0d_op got %b expected %b", j, alu_op, ops[j]); end
                end
                if (i < 9) tick();
            end
        end
        start = 1'b0;
    endtask

    task automatic test_load();
        logic [11:0] seq [10];
        seq = '{O_FADDR, O_FMEM, O_FMBR, O_FIR, O_DEC, O_EADDR, O_EMEM, O_EMBR, O_ELD, O_FADDR};
        ir = 16'h1234;
        #1;
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (outs() !== seq[i]) begin n_bad++; $display("FAIL load_c%0d got %h expected %h", i, outs(), seq[i]); end
            if (i < 9) tick();
        end
    endtask

    task automatic test_store();
        logic [11:0] seq [8];
        seq = '{O_FADDR, O_FMEM, O_FMBR, O_FIR, O_DEC, O_EADDR, O_EST, O_FADDR};
        ir = 16'h2045;
        #1;
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (outs() !== seq[i]) begin n_bad++; $display("FAIL store_c%0d got %h expected %h", i, outs(), seq[i]); end
            if (i < 7) tick();
        end
    endtask

    task automatic test_jump();
        logic [11:0] seq [6];
        seq = '{O_FADDR, O_FMEM, O_FMBR, O_FIR, O_DECJ, O_FADDR};
        ir = 16'h8123;
        #1;
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (outs() !== seq[i]) begin n_bad++; $display("FAIL jump_c%0d got %h expected %h", i, outs(), seq[i]); end
            if (i == 4) begin
                n_cmp++;
                if (pc_load_val !== 16'h0123) begin n_bad++; $display("FAIL jump_target got %h expected %h", pc_load_val, 16'h0123); end
            end
            if (i < 5) tick();
        end
    endtask

    task automatic test_halt();
        logic [11:0] seq [7];
        seq = '{O_FADDR, O_FMEM, O_FMBR, O_FIR, O_DEC, HLT, HLT};
        ir = 16'hF000;
        #1;
        for (int i = 0; i < 7; i++) begin
            n_cmp++;
            if (outs() !== seq[i]) begin n_bad++; $display("FAIL halt_c%0d got %h expected %h", i, outs(), seq[i]); end
            if (i < 6) tick();
        end
        start = 1'b1;
        #1;
        n_cmp++;
        if (outs() !== HLT) begin n_bad++; $display("FAIL halt_start got %h expected %h", outs(), HLT); end
        tick();
        start = 1'b0;
        #1;
        n_cmp++;
        if (outs() !== O_FADDR) begin n_bad++; $display("FAIL halt_resume got %h expected %h", outs(), O_FADDR); end
    endtask

    task automatic test_reset_mid_store();
        logic [11:0] seq [7];
        seq = '{O_FADDR, O_FMEM, O_FMBR, O_FIR, O_DEC, O_EADDR, O_EST};
        ir = 16'h2045;
        acc = 16'h5A5A;
        #1;
        for (int i = 0; i < 7; i++) begin
            n_cmp++;
            if (outs() !== seq[i]) begin n_bad++; $display("FAIL mid_store_c%0d got %h expected %h", i, outs(), seq[i]); end
            if (i < 6) tick();
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (mem_we !== 1'b0) begin n_bad++; $display("FAIL mid_store_we got %b expected %b", mem_we, 1'b0); end
        n_cmp++;
        if (outs() !== 12'h000) begin n_bad++; $display("FAIL mid_store_outs got %h expected %h", outs(), 12'h000); end
        tick();
        reset = 1'b1;
        tick();
        n_cmp++;
        if (outs() !== 12'h000) begin n_bad++; $display("FAIL mid_store_idle got %h expected %h", outs(), 12'h000); end
        begin_run(16'h0000);
    endtask

    task automatic test_cond_jump();
`ifdef CTRL_COND_JUMP_EN
        logic [15:0] words [4];
        logic [15:0] accs [4];
        logic [11:0] dec_exp [4];
        logic [11:0] seq [6];
        words   = '{16'h9040, 16'hA7FF, 16'h9040, 16'hA040};
        accs    = '{16'h0000, 16'h8000, 16'h0001, 16'h7FFF};
        dec_exp = '{O_DECJ, O_DECJ, O_DEC, O_DEC};
        for (int j = 0; j < 4; j++) begin
            ir = words[j];
            acc = accs[j];
            seq = '{O_FADDR, O_FMEM, O_FMBR, O_FIR, dec_exp[j], O_FADDR};
            #1;
            for (int i = 0; i < 6; i++) begin
                n_cmp++;
                if (outs() !== seq[i]) begin n_bad++; $display("FAIL cond%0d_c%0d got %h expected %h", j, i, outs(), seq[i]); end
                if (i == 4 && j < 2) begin
                    n_cmp++;
                    if (pc_load_val !== {4'h0, words[j][11:0]}) begin n_bad++; $display("FAIL cond%0d_target got %h expected %h", j, pc_load_val, {4'h0, words[j][11:0]}); end
                end
                if (i < 5) tick();
            end
        end
`else
        logic [11:0] seq [7];
        seq = '{O_FADDR, O_FMEM, O_FMBR, O_FIR, O_DEC, TRP, TRP};
        ir = 16'h9040;
        acc = 16'h0000;
        #1;
        for (int i = 0; i < 7; i++) begin
            n_cmp++;
            if (outs() !== seq[i]) begin n_bad++; $display("FAIL jz_trap_c%0d got %h expected %h", i, outs(), seq[i]); end
            if (i < 6) tick();
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (outs() !== 12'h000) begin n_bad++; $display("FAIL jz_trap_reset got %h expected %h", outs(), 12'h000); end
        tick();
        reset = 1'b1;
        tick();
        begin_run(16'h0000);
`endif
    endtask

    task automatic test_trap();
        logic [11:0] seq [6];
        seq = '{O_FADDR, O_FMEM, O_FMBR, O_FIR, O_DEC, TRP};
        ir = 16'hC000;
        #1;
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (outs() !== seq[i]) begin n_bad++; $display("FAIL trap_c%0d got %h expected %h", i, outs(), seq[i]); end
            if (i < 5) tick();
        end
        for (int k = 0; k < 3; k++) begin
            start = 1'b1;
            #1;
            n_cmp++;
            if (outs() !== TRP) begin n_bad++; $display("FAIL trap_start%0d got %h expected %h", k, outs(), TRP); end
            tick();
            start = 1'b0;
            n_cmp++;
            if (outs() !== TRP) begin n_bad++; $display("FAIL trap_hold%0d got %h expected %h", k, outs(), TRP); end
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (outs() !== 12'h000) begin n_bad++; $display("FAIL trap_reset got %h expected %h", outs(), 12'h000); end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_alu();
        test_load();
        test_store();
        test_jump();
        test_halt();
        test_reset_mid_store();
        test_cond_jump();
        test_trap();
        release_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter ADDR_W, default 12, SHALL set the operand-address field width; instruction word is 16 bits, opcode [15:12], operand [ADDR_W-1:0].
REQ-002 Parameter RESET_PC, default 16'h0000, SHALL be the value requested on pc_load_val at the first fetch after reset.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-005 start  input  1  single-cycle pulse; begins or resumes execution from IDLE.
REQ-006 ir  input  16  current Instruction Register contents.
REQ-007 acc  input  16  current Accumulator contents (zero/sign tests).
REQ-008 mar_load, mbr_load, ir_load, acc_load, pc_inc, pc_load, mem_we  output  1 each  datapath register/memory strobes.
REQ-009 mar_sel  output  1  0 = MAR source is PC, 1 = MAR source is ir operand.
REQ-010 acc_sel  output  1  0 = ACC source is ALU result, 1 = ACC source is MBR.
REQ-011 alu_op  output  3  ALU opcode: 000 add, 001 sub, 010 and, 011 or, 100 xor.
REQ-012 pc_load_val  output  16  jump target, zero-extended ir operand (or RESET_PC).
REQ-013 busy, halted, trap  output  1 each  status flags.

Function
REQ-014 States SHALL be IDLE, F_ADDR, F_MEM, F_MBR, F_IR, DECODE, E_ADDR, E_MEM, E_MBR, E_DO, E_STORE, HALT, TRAP.
REQ-015 IDLE SHALL move to F_ADDR only on start=1; F_ADDR asserts mar_load, mar_sel=0.
REQ-016 F_MEM is the synchronous-read wait cycle (no strobes); F_MBR asserts mbr_load; F_IR asserts ir_load and pc_inc; then DECODE.
REQ-017 Opcodes: 0 NOP, 1 LOAD, 2 STORE, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR, 8 JUMP, 9 JZ, A JNEG, F HALT; all others illegal.
REQ-018 DECODE: NOP -> F_ADDR; JUMP -> pc_load=1, F_ADDR; HALT -> HALT; illegal -> TRAP; LOAD/ALU ops/STORE -> E_ADDR.
REQ-019 E_ADDR asserts mar_load, mar_sel=1; then E_STORE for STORE, else E_MEM -> E_MBR (mbr_load) -> E_DO.
REQ-020 E_DO asserts acc_load; LOAD uses acc_sel=1; ADD..XOR use acc_sel=0 and alu_op = opcode-3; then F_ADDR.
REQ-021 E_STORE asserts mem_we for exactly one cycle (memory data_in = acc); then F_ADDR.
REQ-022 Latency start-of-fetch to next F_ADDR: NOP/JUMP 5 cycles, STORE 7, LOAD/ALU 9.
REQ-023 Every strobe SHALL be 0 in any state not listing it; mem_we and pc_load never co-asserted with pc_inc.
REQ-024 HALT: halted=1, no strobes; start returns to F_ADDR (PC already points past HALT).
REQ-025 TRAP: trap=1, no strobes, exit only by reset; start ignored.
REQ-026 busy=1 in all states except IDLE, HALT, TRAP; start ignored while busy.
REQ-027 First fetch after reset SHALL pulse pc_load with pc_load_val=RESET_PC during F_ADDR's preceding IDLE->F_ADDR transition cycle.

Reset
REQ-028 reset=0 SHALL force IDLE immediately, all strobes 0, busy/halted/trap 0, alu_op 000, pc_load_val 0, regardless of state (including mid-E_STORE).
REQ-029 Deassertion takes effect at the next clk rising edge; no strobe pulses during the release cycle.

Configuration
REQ-030 Macro CTRL_COND_JUMP_EN defined: JZ loads PC when acc==0, JNEG when acc[15]==1, else no-op; both leave DECODE to F_ADDR.
REQ-031 Macro undefined: opcodes 9 and A SHALL be illegal and enter TRAP.

Structure
REQ-032 Package ctrl_pkg SHALL hold the state enum, 4-bit opcode enum, alu_op constants and instruction field positions.
REQ-033 Combinational sub-module ctrl_decode SHALL map opcode (+acc flags) to next-state class and alu_op; FSM stays in control_sequencer.

Verification
REQ-034 Reset mid-E_STORE -> mem_we drops same cycle, state IDLE, all outputs 0.
REQ-035 ir=16'h3005 after start -> mar_sel=1 at E_ADDR, acc_load with alu_op=000, acc_sel=0 at cycle 9.
REQ-036 ir=16'h8123 -> pc_load=1, pc_load_val=16'h0123 at DECODE, next F_ADDR at cycle 5.
REQ-037 ir=16'h9040, acc=0, macro defined -> pc_load=1, pc_load_val=16'h0040; macro undefined -> trap=1, stays until reset.
REQ-038 ir=16'hF000 -> halted=1, busy=0; start pulse -> busy=1, mar_load at next cycle.
REQ-039 ir=16'hC000 -> trap=1; start pulses ignored; reset=0 clears trap.
